// File: rtl/vga_timing_driver.sv
// vga_timing_driver: 640x480@60 VGA raster timing with coordinate export and latency-aligned RGB/sync pins.
// Ports:
//   clk          pixel clock (25 MHz)
//   rst          asynchronous active-high reset
//   VGA_data     12-bit colour returned by pixel producers, DATA_LAT clk after the coordinate
//   VGA_xpos     current column 1..H_ACTIVE when visible, else 0
//   VGA_ypos     current row 1..V_ACTIVE when visible, else 0
//   frame_start  one-cycle pulse with the first visible pixel of each frame
//   vga_hs/vs    active-low syncs, aligned with vga_r/g/b
//   vga_r/g/b    4-bit DAC outputs, forced to 0 during blanking
// Optional: define VGA_TEST_PATTERN_EN to replace VGA_data with eight 80-column colour bars.
module vga_timing_driver #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int DATA_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] VGA_data,
    output logic [10:0] VGA_xpos,
    output logic [10:0] VGA_ypos,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);
    localparam logic [9:0] HA  = 10'(H_ACTIVE);
    localparam logic [9:0] HS0 = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS1 = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] HT1 = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VA  = 10'(V_ACTIVE);
    localparam logic [9:0] VS0 = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS1 = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] VT1 = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [10:0] xpos_q, ypos_q;
    logic        fs_q, hs_q, vs_q;
    logic [11:0] rgb_q, rgb_d, pix;
    logic        act, hs_raw, vs_raw;
    // {active, hs, vs} per pixel; stage k holds the pixel whose coordinate was presented k clk ago
    logic [2:0]  sr_q [DATA_LAT+1];

    always_comb begin
        hcnt_d = (hcnt_q == HT1) ? 10'd0 : hcnt_q + 10'd1;
        vcnt_d = (hcnt_q != HT1) ? vcnt_q : (vcnt_q == VT1) ? 10'd0 : vcnt_q + 10'd1;
        act    = (hcnt_q < HA) && (vcnt_q < VA);
        hs_raw = !((hcnt_q >= HS0) && (hcnt_q < HS1));
        vs_raw = !((vcnt_q >= VS0) && (vcnt_q < VS1));
        rgb_d  = sr_q[DATA_LAT][2] ? pix : 12'd0;
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar_q [DATA_LAT+1];

    function automatic logic [2:0] bar_of(input logic [9:0] h);
        bar_of = 3'd0;
        for (int i = 1; i < 8; i++)
            if (h >= 10'(80 * i)) bar_of = 3'(i);
    endfunction

    // Bar order FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000 decodes to R=~b[1], G=~b[2], B=~b[0]
    assign pix = {{4{~bar_q[DATA_LAT][1]}}, {4{~bar_q[DATA_LAT][2]}}, {4{~bar_q[DATA_LAT][0]}}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= DATA_LAT; i++) bar_q[i] <= 3'd0;
        end else begin
            bar_q[0] <= bar_of(hcnt_q);
            for (int i = 1; i <= DATA_LAT; i++) bar_q[i] <= bar_q[i-1];
        end
    end
`else
    assign pix = VGA_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= 10'd0;
            vcnt_q <= 10'd0;
            xpos_q <= 11'd0;
            ypos_q <= 11'd0;
            fs_q   <= 1'b0;
            // syncs idle high through the pipeline so release cannot emit a stray pulse
            for (int i = 0; i <= DATA_LAT; i++) sr_q[i] <= 3'b011;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            rgb_q  <= 12'd0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            xpos_q <= act ? {1'b0, hcnt_q + 10'd1} : 11'd0;
            ypos_q <= act ? {1'b0, vcnt_q + 10'd1} : 11'd0;
            fs_q   <= (hcnt_q == 10'd0) && (vcnt_q == 10'd0);
            sr_q[0] <= {act, hs_raw, vs_raw};
            for (int i = 1; i <= DATA_LAT; i++) sr_q[i] <= sr_q[i-1];
            hs_q   <= sr_q[DATA_LAT][1];
            vs_q   <= sr_q[DATA_LAT][0];
            rgb_q  <= rgb_d;
        end
    end

    assign VGA_xpos    = xpos_q;
    assign VGA_ypos    = ypos_q;
    assign frame_start = fs_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign {vga_r, vga_g, vga_b} = rgb_q;
endmodule

// File: tb/tb_vga_timing_driver.sv
// tb_vga_timing_driver: scoreboard bench for vga_timing_driver on a shrunken raster, model built from pixel index arithmetic.
module tb_vga_timing_driver;
    localparam int HA = 40, HF = 4, HS = 6, HB = 5, HT = HA + HF + HS + HB;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int DL = 2;

    typedef struct packed {logic [10:0] x; logic [10:0] y; logic fs;} crd_t;
    typedef struct packed {logic hs; logic vs; logic [11:0] rgb;} pin_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] VGA_data = 12'd0;
    logic [10:0] VGA_xpos, VGA_ypos;
    logic        frame_start, vga_hs, vga_vs;
    logic [3:0]  vga_r, vga_g, vga_b;

    crd_t        cq[$];
    pin_t        pq[$];
    logic [11:0] dq[$];
    int          k = 0;
    int          passed = 0, total = 0, nfail = 0;

    vga_timing_driver #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .DATA_LAT(DL)
    ) dut (
        .clk(clk), .rst(rst), .VGA_data(VGA_data),
        .VGA_xpos(VGA_xpos), .VGA_ypos(VGA_ypos), .frame_start(frame_start),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else begin
            nfail++;
            if (nfail <= 30) $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_xpos", VGA_xpos, 0);
        chk("rst_ypos", VGA_ypos, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_hs", vga_hs, 1);
        chk("rst_vs", vga_vs, 1);
        chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    endtask

    // Stimulus: predicts the pixel of the coming edge, plays the producer with a DL-deep data delay
    always @(negedge clk) begin
        if (rst) begin
            k = 0;
            cq.delete();
            pq.delete();
            dq.delete();
        end else begin
            int p, h, v;
            logic a;
            logic [10:0] ex, ey;
            logic [11:0] c;
            k++;
            p  = k - 1;
            h  = p % HT;
            v  = (p / HT) % VT;
            a  = (h < HA) && (v < VA);
            ex = a ? 11'(h + 1) : 11'd0;
            ey = a ? 11'(v + 1) : 11'd0;
            cq.push_back({ex, ey, (p % (HT * VT)) == 0});
            case ($urandom_range(0, 2))
                0: c = {ex[3:0], ey[3:0], 4'hA};
                1: c = 12'hFFF;
                default: c = 12'($urandom);
            endcase
            pq.push_back({!(h >= HA + HF && h < HA + HF + HS), !(v >= VA + VF && v < VA + VF + VS), a ? c : 12'h0});
            dq.push_back(c);
            if (dq.size() > DL + 1) VGA_data = dq.pop_front();
            else VGA_data = 12'($urandom);
        end
    end

    // Monitor: coordinates every edge; pins once the DL+1 pipeline has filled, reset-idle before that
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            crd_t ec;
            pin_t ep;
            if (cq.size() == 0) begin
                total++;
                nfail++;
                $display("FAIL coord_queue: got empty expected entry at t=%0t", $time);
            end else begin
                ec = cq.pop_front();
                chk("xpos", VGA_xpos, ec.x);
                chk("ypos", VGA_ypos, ec.y);
                chk("frame_start", frame_start, ec.fs);
            end
            if (pq.size() >= DL + 2) ep = pq.pop_front();
            else ep = {1'b1, 1'b1, 12'h0};
            chk("vga_hs", vga_hs, ep.hs);
            chk("vga_vs", vga_vs, ep.vs);
            chk("rgb", {vga_r, vga_g, vga_b}, ep.rgb);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk_reset();
        rst = 1'b0;
        repeat (2 * HT * VT + $urandom_range(200, 400)) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset();
        repeat (5) @(posedge clk);
        #1 chk_reset();
        #1 rst = 1'b0;
        repeat (HT * VT + 200) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vga_timing_driver.md
Name: vga_timing_driver

Overview:
- Display-side end of the pixel interface: generates 640x480@60 Hz VGA raster timing on the 25 MHz pixel clock.
- Publishes the current pixel coordinate (VGA_xpos/VGA_ypos) to the game pixel producers.
- Accepts their returned 12-bit VGA_data after a fixed pipeline latency.
- Drives the board's sync and RGB pins with sync and blanking aligned to that data.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clk cycles)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- DATA_LAT, 2, clk cycles from VGA_xpos/VGA_ypos valid to matching VGA_data valid at input (range 1..8)

Ports:
- clk  in  1  pixel clock, 25 MHz
- rst  in  1  asynchronous, active-high reset
- VGA_data  in  12  pixel colour from producers; [11:8]=R, [7:4]=G, [3:0]=B
- VGA_xpos  out  11  current column, 1..H_ACTIVE when visible, 0 when blanked
- VGA_ypos  out  11  current row, 1..V_ACTIVE when visible line, 0 otherwise
- frame_start  out  1  one-cycle pulse at first visible pixel of each frame
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_r  out  4  red to DAC
- vga_g  out  4  green to DAC
- vga_b  out  4  blue to DAC

Behaviour:
- Counters: hcnt 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800); vcnt 0..V_TOTAL-1 (525).
  - hcnt increments every clk and wraps to 0.
  - vcnt increments when hcnt wraps; vcnt wraps to 0 when both are at terminal count in the same cycle.
- Region order per line and frame: active, front porch, sync, back porch.
  - Active: hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- Coordinate outputs are registered from the counters (1 clk):
  - VGA_xpos = hcnt+1 when pixel active, else 0.
  - VGA_ypos = vcnt+1 when vcnt < V_ACTIVE and hcnt < H_ACTIVE, else 0.
- frame_start = 1 for exactly the cycle in which VGA_xpos=1 and VGA_ypos=1.
- Raw sync: hs_raw low when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC (656..751); vs_raw low when vcnt in 490..491 (whole lines, including hcnt 0..799).
- Alignment pipeline: hs, vs and active flag pass through a shift register so that all of the following land on the same output edge, DATA_LAT+1 clk after VGA_xpos/VGA_ypos present that pixel:
  - vga_hs, vga_vs
  - vga_r/g/b sampled from VGA_data
- Blanking: when the delayed active flag is 0, vga_r/g/b = 0 regardless of VGA_data.
- Latency, fixed: coordinate to pins = DATA_LAT+1 clk. Pipeline is never stalled; no back-pressure.
- Reset, asynchronous:
  - Counters, shift registers, frame_start, VGA_xpos, VGA_ypos and RGB clear to 0.
  - vga_hs and vga_vs go to 1 (inactive); delayed sync stages reset to 1 so no spurious sync pulse after release.
  - Reset mid-frame restarts at hcnt=vcnt=0.
  - First edge after release presents VGA_xpos=1, VGA_ypos=1, frame_start=1.
- Widths: counters 10 bits; coordinates zero-extended to 11 bits; no arithmetic overflow for default parameters.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN
- Defined: VGA_data is ignored. RGB in the active region is 8 vertical colour bars, each 80 columns wide, selected by (VGA_xpos-1)/80:
  - Colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - Same DATA_LAT+1 alignment and blanking apply.
- Undefined: RGB comes from VGA_data only; no pattern logic synthesized.

Test Plan:
- Reset release, observe 420000 clk -> frame_start pulses exactly at cycles 1 and 420001 after release; VGA_xpos sequence 1..640 then 160 zeros per visible line; VGA_ypos stays 0 for lines 481..525.
- Measure sync -> vga_hs low 96 clk every 800 clk, falling edge DATA_LAT+1+656 clk after VGA_xpos=1; vga_vs low 1600 clk every 420000 clk.
- Drive VGA_data = {xpos[3:0], ypos[3:0], 4'hA} from the bench with DATA_LAT=2 -> vga_r/g/b equal the value computed from the coordinate 3 clk earlier; all zero during blanking even when VGA_data=12'hFFF.
- Assert rst at hcnt=300, vcnt=200 for 5 clk -> vga_hs=vga_vs=1, RGB=0, VGA_xpos=0 immediately; restart with frame_start on first edge after release; no vga_hs low pulse within the first 656 clk after release.
- Rebuild with DATA_LAT=4 -> RGB/sync alignment shifts to 5 clk; hs period still 800.
- Build with VGA_TEST_PATTERN_EN -> VGA_xpos=81 produces RGB 12'hFF0 and VGA_xpos=640 produces 12'h000, each 3 clk later.
